// File: rtl/lcd_scan_driver.sv
// Frame scanner: walks the 128x64 frame buffer through the decider pixel port and
// streams row headers plus pixel bytes to a 3-wire serial LCD with a one-byte prefetch.
module lcd_scan_driver #(
  parameter int COLS = 16,
  parameter int ROWS = 64
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       frame_start,
  output logic       busy,
  output logic       frame_done,
  output logic [9:0] addrD,
  output logic       en,
  input  logic [7:0] dataD,
  output logic       lcd_cs,
  output logic       lcd_sclk,
  output logic       lcd_sdo,
  output logic       lcd_rs
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [1:0] F_A = 2'd0;
  localparam logic [1:0] F_B = 2'd1;
  localparam logic [1:0] F_C = 2'd2;
  localparam logic [1:0] F_D = 2'd3;

  localparam logic [4:0] LAST_ITEM = 5'(COLS);
  localparam logic [5:0] LAST_ROW  = 6'(ROWS - 1);

  logic [1:0] state_r;
  logic [4:0] item_r;
  logic [5:0] row_r;
  logic [1:0] ph_r;
  logic       fetch_done_r;

  logic [7:0] buf_data_r;
  logic       buf_rs_r;
  logic       buf_full_r;

  logic [7:0] sh_byte_r;
  logic [3:0] k_r;
  logic       sh_active_r;

  logic       run_s;
  logic       fetch_on_s;
  logic       wr_en_s;
  logic [7:0] wr_data_s;
  logic       wr_rs_s;
  logic       load_s;
  logic       bypass_s;
  logic [7:0] src_data_s;
  logic       src_rs_s;
  logic [3:0] k_next_s;
  logic       frame_end_s;

  assign run_s      = (state_r == S_RUN);
  assign fetch_on_s = run_s && !fetch_done_r;
  // The shifter may take a new byte when idle or in its last bit phase.
  assign load_s      = run_s && (!sh_active_r || (k_r == 4'd15)) && (buf_full_r || wr_en_s);
  assign bypass_s    = load_s && !buf_full_r;
  assign src_data_s  = buf_full_r ? buf_data_r : wr_data_s;
  assign src_rs_s    = buf_full_r ? buf_rs_r : wr_rs_s;
  assign k_next_s    = k_r + 4'd1;
  assign frame_end_s = run_s && fetch_done_r && !buf_full_r && sh_active_r && (k_r == 4'd15);

  // Fetcher write port into the prefetch buffer
  always_comb begin
    wr_en_s   = 1'b0;
    wr_data_s = 8'd0;
    wr_rs_s   = 1'b0;
    if (fetch_on_s) begin
      if (item_r == 5'd0) begin
        wr_en_s   = !buf_full_r;
        wr_data_s = {2'b10, row_r};
        wr_rs_s   = 1'b0;
      end else if (ph_r == F_D) begin
        wr_en_s   = 1'b1;
        wr_data_s = dataD;
        wr_rs_s   = 1'b1;
      end else begin
        wr_en_s   = 1'b0;
        wr_data_s = 8'd0;
        wr_rs_s   = 1'b0;
      end
    end else begin
      wr_en_s   = 1'b0;
      wr_data_s = 8'd0;
      wr_rs_s   = 1'b0;
    end
  end

  // Top frame FSM with busy, chip select and done pulse
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r    <= S_IDLE;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      lcd_cs     <= 1'b1;
    end else begin
      case (state_r)
        S_IDLE: begin
          frame_done <= 1'b0;
          if (frame_start) begin
            state_r <= S_RUN;
            busy    <= 1'b1;
            lcd_cs  <= 1'b0;
          end
        end
        S_RUN: begin
          if (frame_end_s) begin
            state_r    <= S_DONE;
            busy       <= 1'b0;
            lcd_cs     <= 1'b1;
            frame_done <= 1'b1;
          end else begin
            frame_done <= 1'b0;
          end
        end
        S_DONE: begin
          // busy is already low here, so a request in this cycle is honoured.
          frame_done <= 1'b0;
          if (frame_start) begin
            state_r <= S_RUN;
            busy    <= 1'b1;
            lcd_cs  <= 1'b0;
          end else begin
            state_r <= S_IDLE;
          end
        end
        default: begin
          state_r    <= S_IDLE;
          busy       <= 1'b0;
          frame_done <= 1'b0;
          lcd_cs     <= 1'b1;
        end
      endcase
    end
  end

  // Fetcher: item/row counters and the 4-phase decider handshake
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      item_r       <= 5'd0;
      row_r        <= 6'd0;
      ph_r         <= F_A;
      fetch_done_r <= 1'b0;
      addrD        <= 10'd0;
      en           <= 1'b0;
    end else if (state_r == S_DONE) begin
      fetch_done_r <= 1'b0;
      ph_r         <= F_A;
      en           <= 1'b0;
    end else if (fetch_on_s) begin
      if (item_r == 5'd0) begin
        if (!buf_full_r) begin
          item_r <= 5'd1;
          ph_r   <= F_A;
          addrD  <= {4'd0, row_r};
        end
      end else begin
        case (ph_r)
          F_A: if (!buf_full_r) ph_r <= F_B;
          F_B: begin
            ph_r <= F_C;
            en   <= 1'b1;
          end
          F_C: ph_r <= F_D;
          F_D: begin
            en   <= 1'b0;
            ph_r <= F_A;
            if (item_r == LAST_ITEM) begin
              item_r <= 5'd0;
              if (row_r == LAST_ROW) begin
                row_r        <= 6'd0;
                fetch_done_r <= 1'b1;
              end else begin
                row_r <= row_r + 6'd1;
              end
            end else begin
              // Next column index equals the current item number.
              item_r <= item_r + 5'd1;
              addrD  <= {item_r[3:0], row_r};
            end
          end
          default: begin
            ph_r <= F_A;
            en   <= 1'b0;
          end
        endcase
      end
    end
  end

  // Prefetch buffer; a direct hand-over to an idle shifter leaves it empty
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      buf_data_r <= 8'd0;
      buf_rs_r   <= 1'b0;
      buf_full_r <= 1'b0;
    end else if (!run_s) begin
      buf_full_r <= 1'b0;
    end else if (wr_en_s && !bypass_s) begin
      buf_data_r <= wr_data_s;
      buf_rs_r   <= wr_rs_s;
      buf_full_r <= 1'b1;
    end else if (load_s) begin
      buf_full_r <= 1'b0;
    end
  end

  // Serial shifter: 16 phases per byte, sclk = k[0], MSB first
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sh_byte_r   <= 8'd0;
      k_r         <= 4'd15;
      sh_active_r <= 1'b0;
      lcd_sclk    <= 1'b0;
      lcd_sdo     <= 1'b0;
      lcd_rs      <= 1'b0;
    end else if (load_s) begin
      sh_byte_r   <= src_data_s;
      k_r         <= 4'd0;
      sh_active_r <= 1'b1;
      lcd_sclk    <= 1'b0;
      lcd_sdo     <= src_data_s[7];
      lcd_rs      <= src_rs_s;
    end else if (sh_active_r && (k_r != 4'd15)) begin
      k_r      <= k_next_s;
      lcd_sclk <= k_next_s[0];
      lcd_sdo  <= sh_byte_r[3'd7 - k_next_s[3:1]];
    end else begin
      sh_active_r <= 1'b0;
      k_r         <= 4'd15;
      lcd_sclk    <= 1'b0;
      lcd_sdo     <= 1'b0;
      lcd_rs      <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lcd_scan_driver.sv
// Self-checking bench for lcd_scan_driver: per-cycle frame timing model, serial
// decoder and directed scenarios (mid-frame reset, ignored requests, back-to-back).
module tb_lcd_scan_driver;

  localparam int FRAME_LEN = 17410;
  localparam int NBYTES    = 1088;
  localparam int NONE      = -100000;

  logic       clk = 1'b0;
  logic       rstn;
  logic       frame_start;
  logic       busy, frame_done, en;
  logic [9:0] addrD;
  logic [7:0] dataD;
  logic       lcd_cs, lcd_sclk, lcd_sdo, lcd_rs;

  lcd_scan_driver #(.COLS(16), .ROWS(64)) dut (
    .clk(clk), .rstn(rstn), .frame_start(frame_start), .busy(busy),
    .frame_done(frame_done), .addrD(addrD), .en(en), .dataD(dataD),
    .lcd_cs(lcd_cs), .lcd_sclk(lcd_sclk), .lcd_sdo(lcd_sdo), .lcd_rs(lcd_rs)
  );

  // Decider model: pixel byte is the low address byte.
  assign dataD = addrD[7:0];

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;
  int t_cur = NONE;
  int t_prev = NONE;
  logic [8:0] dec[$];
  logic [7:0] sh;
  int nb = 0;
  int en_pulses = 0;
  int cs_run = 0;
  int cs_last_run = 0;
  logic prev_sclk = 1'b0;
  logic prev_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, req);
    end
  endtask

  // Byte n of a frame as {rs, data}: row header then 16 pixel bytes {c[1:0], r}.
  function automatic logic [8:0] byte_of(int n);
    int r = n / 17;
    int i = n % 17;
    logic [5:0] rr = 6'(r);
    logic [3:0] c = 4'(i - 1);
    if (i == 0) return {1'b0, 2'b10, rr};
    return {1'b1, c[1:0], rr};
  endfunction

  // Expected {busy, frame_done, cs, sclk, sdo, rs, en} in cycle T+d.
  function automatic logic [6:0] exp_out(int d);
    int n, k;
    logic [8:0] b;
    logic en_e;
    if (d == 1) return 7'b1000000;
    if (d >= 2 && d <= FRAME_LEN - 1) begin
      n = (d - 2) / 16;
      k = (d - 2) % 16;
      b = byte_of(n);
      en_e = (k == 2 || k == 3) && ((n + 1) % 17 != 0) && (n + 1 < NBYTES);
      return {1'b1, 1'b0, 1'b0, 1'(k % 2), b[7 - k / 2], b[8], en_e};
    end
    if (d == FRAME_LEN) return 7'b0110000;
    return 7'b0010000;
  endfunction

  // Address the decider must see in the 4-cycle fetch window, or -1.
  function automatic int exp_addr(int d);
    int n, k, m;
    if (d < 2 || d > FRAME_LEN - 1) return -1;
    n = (d - 2) / 16;
    k = (d - 2) % 16;
    m = n + 1;
    if (k <= 3 && (m % 17) != 0 && m < NBYTES) return ((m % 17) - 1) * 64 + (m / 17);
    return -1;
  endfunction

  // Per-cycle compare, serial decoder and pulse counters
  initial begin
    int d;
    int ea;
    logic [6:0] e;
    forever begin
      @(negedge clk);
      if (cyc - t_cur >= 1 && cyc - t_cur <= FRAME_LEN) d = cyc - t_cur;
      else d = cyc - t_prev;
      e = exp_out(d);
      check("outputs{busy,done,cs,sclk,sdo,rs,en}",
            {25'd0, busy, frame_done, lcd_cs, lcd_sclk, lcd_sdo, lcd_rs, en}, {25'd0, e});
      ea = exp_addr(d);
      if (ea >= 0) check("addrD", {22'd0, addrD}, 32'(ea));
      if (!prev_sclk && lcd_sclk) begin
        sh = {sh[6:0], lcd_sdo};
        nb++;
        if (nb == 8) begin
          dec.push_back({lcd_rs, sh});
          nb = 0;
        end
      end
      if (!prev_en && en) en_pulses++;
      if (lcd_cs) cs_run++;
      else if (cs_run > 0) begin
        cs_last_run = cs_run;
        cs_run = 0;
      end
      prev_sclk = lcd_sclk;
      prev_en = en;
    end
  end

  task automatic start_frame();
    frame_start = 1'b1;
    t_prev = t_cur;
    t_cur = cyc;
    dec.delete();
    nb = 0;
    en_pulses = 0;
    @(posedge clk); #2;
    frame_start = 1'b0;
  endtask

  task automatic wait_done(output int at);
    at = -1;
    for (int i = 0; i < 20000 && at < 0; i++) begin
      if (frame_done) at = cyc;
      else begin
        @(posedge clk); #2;
      end
    end
  endtask

  task automatic check_frame_content();
    int bad = 0;
    check("byte_count", 32'(dec.size()), 32'(NBYTES));
    for (int i = 0; i < dec.size() && i < NBYTES; i++)
      if (dec[i] !== byte_of(i)) bad++;
    check("byte_stream_errors", 32'(bad), 32'd0);
    if (dec.size() == NBYTES) begin
      check("byte0_hdr_row0", 32'(dec[0]), 32'h080);
      check("byte1_c0_r0", 32'(dec[1]), 32'h100);
      check("byte2_c1_r0", 32'(dec[2]), 32'h140);
      check("byte17_hdr_row1", 32'(dec[17]), 32'h081);
      check("byte18_c0_r1", 32'(dec[18]), 32'h101);
      check("byte1087_c15_r63", 32'(dec[1087]), 32'h1FF);
    end
    check("en_pulses", 32'(en_pulses), 32'd1024);
  endtask

  initial begin
    int at;
    int tb0;
    rstn = 1'b0;
    frame_start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rstn = 1'b1;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cs", 32'(lcd_cs), 32'd1);
    check("rst_addrD", 32'(addrD), 32'd0);
    repeat (4) @(posedge clk); #2;

    // Frame A, aborted by an asynchronous reset during byte 300 (0x91, k=1).
    start_frame();
    repeat (4802) @(posedge clk); #2;
    check("pre_rst_sclk", 32'(lcd_sclk), 32'd1);
    check("pre_rst_busy", 32'(busy), 32'd1);
    rstn = 1'b0;
    t_cur = NONE;
    t_prev = NONE;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(frame_done), 32'd0);
    check("arst_addrD", 32'(addrD), 32'd0);
    check("arst_en", 32'(en), 32'd0);
    check("arst_cs", 32'(lcd_cs), 32'd1);
    check("arst_sclk", 32'(lcd_sclk), 32'd0);
    check("arst_sdo", 32'(lcd_sdo), 32'd0);
    check("arst_rs", 32'(lcd_rs), 32'd0);
    dec.delete();
    nb = 0;
    repeat (3) @(posedge clk); #2;
    rstn = 1'b1;
    repeat (5) @(posedge clk); #2;

    // Frame B with two requests that must be ignored.
    start_frame();
    tb0 = t_cur;
    repeat (4) @(posedge clk); #2;
    frame_start = 1'b1;
    @(posedge clk); #2;
    frame_start = 1'b0;
    repeat (9000 - (cyc - tb0)) @(posedge clk); #2;
    frame_start = 1'b1;
    @(posedge clk); #2;
    frame_start = 1'b0;
    check("busy_after_ignored", 32'(busy), 32'd1);
    wait_done(at);
    check("frame_b_length", 32'(at - tb0), 32'(FRAME_LEN));
    check_frame_content();

    // Frame C requested in the done cycle: back-to-back.
    start_frame();
    tb0 = t_cur;
    @(posedge clk); #2;
    check("cs_gap_cycles", 32'(cs_last_run), 32'd1);
    wait_done(at);
    check("frame_c_length", 32'(at - tb0), 32'(FRAME_LEN));
    check_frame_content();

    repeat (5) @(posedge clk); #2;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
